// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: ALU and load results queue in small FIFOs and share the register-file write port.
// Optional macro WBARB_RR_EN selects round-robin grant; undefined gives load fixed priority.
module regfile_wb_arbiter #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned DEPTH          = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [4:0]                alu_addr,
  input  logic [BUS_DATA_WIDTH-1:0] alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [4:0]                ld_addr,
  input  logic [BUS_DATA_WIDTH-1:0] ld_data,
  output logic                      write_en,
  output logic [4:0]                addressC,
  output logic [BUS_DATA_WIDTH-1:0] writeBack,
  output logic [31:0]               pending_mask,
  output logic                      idle
);

  localparam int unsigned AW    = 5;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [AW-1:0]             alu_addr_q [DEPTH];
  logic [BUS_DATA_WIDTH-1:0] alu_data_q [DEPTH];
  logic [AW-1:0]             ld_addr_q  [DEPTH];
  logic [BUS_DATA_WIDTH-1:0] ld_data_q  [DEPTH];

  logic [PTR_W-1:0] alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [PTR_W-1:0] ld_wr_q,  ld_wr_d,  ld_rd_q,  ld_rd_d;
  logic [CNT_W-1:0] alu_cnt_q, alu_cnt_d, ld_cnt_q, ld_cnt_d;

  logic                      write_en_q, write_en_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [BUS_DATA_WIDTH-1:0] data_q, data_d;

  logic alu_push, ld_push, alu_ne, ld_ne, pop_alu, pop_ld;
  logic [AW-1:0]             alu_head_addr, ld_head_addr;
  logic [BUS_DATA_WIDTH-1:0] alu_head_data, ld_head_data;

`ifdef WBARB_RR_EN
  logic grant_ld_q, grant_ld_d;
`endif

  // Ready depends only on registered occupancy; forced low while in reset.
  assign alu_ready = !reset && (alu_cnt_q < CNT_W'(DEPTH));
  assign ld_ready  = !reset && (ld_cnt_q  < CNT_W'(DEPTH));
  assign alu_push  = alu_valid && alu_ready;
  assign ld_push   = ld_valid  && ld_ready;

  assign alu_ne        = (alu_cnt_q != '0);
  assign ld_ne         = (ld_cnt_q  != '0);
  assign alu_head_addr = alu_addr_q[alu_rd_q];
  assign alu_head_data = alu_data_q[alu_rd_q];
  assign ld_head_addr  = ld_addr_q[ld_rd_q];
  assign ld_head_data  = ld_data_q[ld_rd_q];

  // Grant selection and next-state for pointers, counts and write port.
  always_comb begin
    pop_alu    = 1'b0;
    pop_ld     = 1'b0;
    write_en_d = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef WBARB_RR_EN
    grant_ld_d = grant_ld_q;
    if (alu_ne && ld_ne) begin
      pop_ld  = grant_ld_q;
      pop_alu = !grant_ld_q;
    end else begin
      pop_alu = alu_ne;
      pop_ld  = ld_ne;
    end
    if (pop_alu)     grant_ld_d = 1'b1;
    else if (pop_ld) grant_ld_d = 1'b0;
`else
    pop_ld  = ld_ne;
    pop_alu = alu_ne && !ld_ne;
`endif
    if (pop_ld) begin
      write_en_d = (ld_head_addr != '0);
      addr_d     = ld_head_addr;
      data_d     = ld_head_data;
    end else if (pop_alu) begin
      write_en_d = (alu_head_addr != '0);
      addr_d     = alu_head_addr;
      data_d     = alu_head_data;
    end
    alu_wr_d  = alu_push ? alu_wr_q + PTR_W'(1) : alu_wr_q;
    alu_rd_d  = pop_alu  ? alu_rd_q + PTR_W'(1) : alu_rd_q;
    ld_wr_d   = ld_push  ? ld_wr_q  + PTR_W'(1) : ld_wr_q;
    ld_rd_d   = pop_ld   ? ld_rd_q  + PTR_W'(1) : ld_rd_q;
    alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(pop_alu);
    ld_cnt_d  = ld_cnt_q  + CNT_W'(ld_push)  - CNT_W'(pop_ld);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_wr_q   <= '0;
      alu_rd_q   <= '0;
      alu_cnt_q  <= '0;
      ld_wr_q    <= '0;
      ld_rd_q    <= '0;
      ld_cnt_q   <= '0;
      write_en_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef WBARB_RR_EN
      grant_ld_q <= 1'b0;
`endif
    end else begin
      alu_wr_q   <= alu_wr_d;
      alu_rd_q   <= alu_rd_d;
      alu_cnt_q  <= alu_cnt_d;
      ld_wr_q    <= ld_wr_d;
      ld_rd_q    <= ld_rd_d;
      ld_cnt_q   <= ld_cnt_d;
      write_en_q <= write_en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
`ifdef WBARB_RR_EN
      grant_ld_q <= grant_ld_d;
`endif
    end
  end

  // FIFO storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_addr_q[alu_wr_q] <= alu_addr;
      alu_data_q[alu_wr_q] <= alu_data;
    end
    if (ld_push) begin
      ld_addr_q[ld_wr_q] <= ld_addr;
      ld_data_q[ld_wr_q] <= ld_data;
    end
  end

  // Pending mask walks the occupied slots from each read pointer.
  always_comb begin
    pending_mask = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < alu_cnt_q) pending_mask[alu_addr_q[alu_rd_q + PTR_W'(k)]] = 1'b1;
      if (CNT_W'(k) < ld_cnt_q)  pending_mask[ld_addr_q[ld_rd_q + PTR_W'(k)]]   = 1'b1;
    end
    if (write_en_q) pending_mask[addr_q] = 1'b1;
    pending_mask[0] = 1'b0;
  end

  assign write_en  = write_en_q;
  assign addressC  = addr_q;
  assign writeBack = data_q;
  assign idle      = (alu_cnt_q == '0) && (ld_cnt_q == '0) && !write_en_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; expectations adapt to WBARB_RR_EN.
module tb_regfile_wb_arbiter;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]   alu_addr, ld_addr, addressC;
  logic [W-1:0] alu_data, ld_data, writeBack;
  logic         write_en, idle;
  logic [31:0]  pending_mask;

  int vecs = 0;
  int errs = 0;

  regfile_wb_arbiter #(.BUS_DATA_WIDTH(W), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .write_en(write_en), .addressC(addressC), .writeBack(writeBack),
    .pending_mask(pending_mask), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [W-1:0] d);
    alu_valid = v; alu_addr = a; alu_data = d;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] a, input logic [W-1:0] d);
    ld_valid = v; ld_addr = a; ld_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_alu(1'b0, 5'd0, '0);
    drive_ld(1'b0, 5'd0, '0);
    step(); step();
    vecs++; if (write_en !== 1'b0 || addressC !== 5'd0 || writeBack !== '0) begin
      errs++; $display("FAIL reset_port got we=%b addr=%0d wb=%h want 0/0/0", write_en, addressC, writeBack);
    end
    vecs++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
      errs++; $display("FAIL reset_ready got alu=%b ld=%b want 0/0", alu_ready, ld_ready);
    end
    reset = 1'b0;
    #1;
    vecs++; if (idle !== 1'b1 || pending_mask !== 32'h0) begin
      errs++; $display("FAIL reset_idle got idle=%b mask=%h want 1/0", idle, pending_mask);
    end
    // Traffic, then reset while valids stay high.
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 5'(2 + i), W'(64'h100 + i));
      drive_ld(1'b1, 5'(12 + i), W'(64'h200 + i));
      step();
    end
    reset = 1'b1;
    #1;
    vecs++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin
      errs++; $display("FAIL midrst_ready got alu=%b ld=%b want 0/0", alu_ready, ld_ready);
    end
    step();
    vecs++; if (write_en !== 1'b0 || addressC !== 5'd0 || writeBack !== '0 || pending_mask !== 32'h0 || idle !== 1'b1) begin
      errs++; $display("FAIL midrst_state got we=%b addr=%0d wb=%h mask=%h idle=%b want 0/0/0/0/1",
                       write_en, addressC, writeBack, pending_mask, idle);
    end
    reset = 1'b0;
    drive_alu(1'b0, 5'd0, '0);
    drive_ld(1'b0, 5'd0, '0);
    #1;
    vecs++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin
      errs++; $display("FAIL postrst_ready got alu=%b ld=%b want 1/1", alu_ready, ld_ready);
    end
    step(); step();
    vecs++; if (write_en !== 1'b0 || idle !== 1'b1) begin
      errs++; $display("FAIL postrst_discard got we=%b idle=%b want 0/1", write_en, idle);
    end
  endtask

  task automatic test_single_alu();
    drive_alu(1'b1, 5'd5, W'(64'hDEAD));
    step();
    drive_alu(1'b0, 5'd0, '0);
    vecs++; if (write_en !== 1'b0 || pending_mask !== 32'h20) begin
      errs++; $display("FAIL single_n1 got we=%b mask=%h want 0/00000020", write_en, pending_mask);
    end
    step();
    vecs++; if (write_en !== 1'b1 || addressC !== 5'd5 || writeBack !== W'(64'hDEAD) || pending_mask !== 32'h20) begin
      errs++; $display("FAIL single_n2 got we=%b addr=%0d wb=%h mask=%h want 1/5/dead/00000020",
                       write_en, addressC, writeBack, pending_mask);
    end
    step();
    vecs++; if (write_en !== 1'b0 || pending_mask !== 32'h0 || idle !== 1'b1) begin
      errs++; $display("FAIL single_n3 got we=%b mask=%h idle=%b want 0/0/1", write_en, pending_mask, idle);
    end
  endtask

  task automatic test_contention();
    logic [4:0] exp_seq [4];
`ifdef WBARB_RR_EN
    exp_seq = '{5'd1, 5'd3, 5'd2, 5'd4};
`else
    exp_seq = '{5'd3, 5'd4, 5'd1, 5'd2};
`endif
    drive_alu(1'b1, 5'd1, W'(64'h111));
    drive_ld(1'b1, 5'd3, W'(64'h333));
    step();
    drive_alu(1'b1, 5'd2, W'(64'h222));
    drive_ld(1'b1, 5'd4, W'(64'h444));
    step();
    drive_alu(1'b0, 5'd0, '0);
    drive_ld(1'b0, 5'd0, '0);
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (write_en !== 1'b1 || addressC !== exp_seq[i] || writeBack !== W'(exp_seq[i]) * W'(64'h111)) begin
        errs++; $display("FAIL contention_slot%0d got we=%b addr=%0d wb=%h want 1/%0d/%h",
                         i, write_en, addressC, writeBack, exp_seq[i], W'(exp_seq[i]) * W'(64'h111));
      end
      step();
    end
    vecs++; if (idle !== 1'b1) begin
      errs++; $display("FAIL contention_idle got %b want 1", idle);
    end
  endtask

  task automatic test_x0();
    drive_alu(1'b1, 5'd0, W'(64'hFFFF));
    step();
    drive_alu(1'b1, 5'd7, W'(64'h77));
    vecs++; if (pending_mask !== 32'h0) begin
      errs++; $display("FAIL x0_queued_mask got %h want 0", pending_mask);
    end
    step();
    drive_alu(1'b0, 5'd0, '0);
    vecs++; if (write_en !== 1'b0 || pending_mask !== 32'h80) begin
      errs++; $display("FAIL x0_slot got we=%b mask=%h want 0/00000080", write_en, pending_mask);
    end
    step();
    vecs++; if (write_en !== 1'b1 || addressC !== 5'd7 || writeBack !== W'(64'h77) || pending_mask[0] !== 1'b0) begin
      errs++; $display("FAIL x0_next got we=%b addr=%0d wb=%h m0=%b want 1/7/77/0",
                       write_en, addressC, writeBack, pending_mask[0]);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] alu_got[$];
    logic [W-1:0] ld_got[$];
    int n_alu = 0;
    int n_ld  = 0;
    bit saw_block = 1'b0;
    bit acc_a, acc_l;
    for (int c = 0; c < 16; c++) begin
      if (c < 5) begin
        drive_alu(1'b1, 5'(8 + (n_alu % 8)), W'(64'hA000 + n_alu));
        drive_ld(1'b1, 5'(16 + (n_ld % 8)), W'(64'hB000 + n_ld));
      end else begin
        drive_alu(1'b0, 5'd0, '0);
        drive_ld(1'b0, 5'd0, '0);
      end
      if (c < 5 && !alu_ready) saw_block = 1'b1;
      acc_a = alu_valid && alu_ready;
      acc_l = ld_valid && ld_ready;
      step();
      if (acc_a) n_alu++;
      if (acc_l) n_ld++;
      if (write_en) begin
        if (addressC >= 5'd8 && addressC < 5'd16) alu_got.push_back(writeBack);
        else if (addressC >= 5'd16 && addressC < 5'd24) ld_got.push_back(writeBack);
      end
    end
    vecs++; if (saw_block !== 1'b1) begin
      errs++; $display("FAIL bp_alu_ready_drop got no drop want a drop");
    end
    vecs++; if (alu_got.size() !== n_alu || ld_got.size() !== n_ld) begin
      errs++; $display("FAIL bp_counts got alu=%0d ld=%0d want alu=%0d ld=%0d", alu_got.size(), ld_got.size(), n_alu, n_ld);
    end
    for (int i = 0; i < alu_got.size(); i++) begin
      vecs++; if (alu_got[i] !== W'(64'hA000 + i)) begin
        errs++; $display("FAIL bp_alu_order[%0d] got %h want %h", i, alu_got[i], W'(64'hA000 + i));
      end
    end
    for (int i = 0; i < ld_got.size(); i++) begin
      vecs++; if (ld_got[i] !== W'(64'hB000 + i)) begin
        errs++; $display("FAIL bp_ld_order[%0d] got %h want %h", i, ld_got[i], W'(64'hB000 + i));
      end
    end
    vecs++; if (idle !== 1'b1) begin
      errs++; $display("FAIL bp_idle got %b want 1", idle);
    end
  endtask

  // Fill one FIFO while its head is being popped and show the offered push waits a cycle.
  task automatic test_full_push_pop();
    bit tgt_ld;
    logic tgt_ready;
`ifdef WBARB_RR_EN
    tgt_ld = 1'b1;
`else
    tgt_ld = 1'b0;
`endif
    if (tgt_ld) begin drive_ld(1'b1, 5'd9, W'(64'hC0)); drive_alu(1'b1, 5'd10, W'(64'hD0)); end
    else        begin drive_alu(1'b1, 5'd9, W'(64'hC0)); drive_ld(1'b1, 5'd10, W'(64'hD0)); end
    step();
    if (tgt_ld) begin drive_ld(1'b1, 5'd11, W'(64'hC1)); drive_alu(1'b0, 5'd0, '0); end
    else        begin drive_alu(1'b1, 5'd11, W'(64'hC1)); drive_ld(1'b0, 5'd0, '0); end
    step();
    tgt_ready = tgt_ld ? ld_ready : alu_ready;
    vecs++; if (tgt_ready !== 1'b0 || addressC !== 5'd10) begin
      errs++; $display("FAIL full_refuse got ready=%b addr=%0d want 0/10", tgt_ready, addressC);
    end
    if (tgt_ld) drive_ld(1'b1, 5'd12, W'(64'hC2)); else drive_alu(1'b1, 5'd12, W'(64'hC2));
    step();
    tgt_ready = tgt_ld ? ld_ready : alu_ready;
    vecs++; if (tgt_ready !== 1'b1 || addressC !== 5'd9 || writeBack !== W'(64'hC0)) begin
      errs++; $display("FAIL full_after_pop got ready=%b addr=%0d wb=%h want 1/9/c0", tgt_ready, addressC, writeBack);
    end
    step();
    if (tgt_ld) drive_ld(1'b0, 5'd0, '0); else drive_alu(1'b0, 5'd0, '0);
    tgt_ready = tgt_ld ? ld_ready : alu_ready;
    vecs++; if (tgt_ready !== 1'b1 || addressC !== 5'd11 || pending_mask !== 32'h1800) begin
      errs++; $display("FAIL full_accept got ready=%b addr=%0d mask=%h want 1/11/00001800", tgt_ready, addressC, pending_mask);
    end
    step();
    vecs++; if (write_en !== 1'b1 || addressC !== 5'd12 || writeBack !== W'(64'hC2)) begin
      errs++; $display("FAIL full_last got we=%b addr=%0d wb=%h want 1/12/c2", write_en, addressC, writeBack);
    end
    step();
    vecs++; if (idle !== 1'b1) begin
      errs++; $display("FAIL full_idle got %b want 1", idle);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_contention();
    test_x0();
    test_backpressure();
    test_full_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (write_en / addressC / writeBack) between two result producers: the ALU result path and the memory-load result path.
- Each producer gets a small FIFO behind a valid/ready handshake. One write per cycle is granted, and the write-port outputs are registered.
- Exports a pending-write mask to the decode stage for RAW hazard checks. Sits between execute/memory and register_file.

Parameters:
- BUS_DATA_WIDTH, 64, width of result data and writeBack.
- DEPTH, 2, entries per requester FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  ALU FIFO can accept.
- alu_addr  input  5  ALU destination register.
- alu_data  input  BUS_DATA_WIDTH  ALU result.
- ld_valid  input  1  load result offered.
- ld_ready  output  1  load FIFO can accept.
- ld_addr  input  5  load destination register.
- ld_data  input  BUS_DATA_WIDTH  load result.
- write_en  output  1  register-file write strobe (registered).
- addressC  output  5  register-file write address (registered).
- writeBack  output  BUS_DATA_WIDTH  register-file write data (registered).
- pending_mask  output  32  bit r = a write to register r is queued or being issued.
- idle  output  1  both FIFOs empty and write_en low.

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk):
  - Both FIFOs emptied; grant pointer = ALU.
  - write_en=0, addressC=0, writeBack=0.
  - Reset values visible the cycle after reset is sampled high.
  - Queued writes are discarded and in-flight handshakes are lost.
  - alu_ready/ld_ready read 0 while reset is high.
- Handshake and FIFO rules:
  - A transfer occurs when valid && ready at posedge.
  - ready = (count < DEPTH), computed from registered count only; no same-cycle pop bypass.
  - Push while full is impossible, because ready is low.
  - Simultaneous push and pop on one FIFO is legal; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - FIFO order within each requester is preserved.
- Arbitration (every cycle, on the FIFO heads):
  - Neither FIFO non-empty: no pop; write_en <= 0.
  - Exactly one FIFO non-empty: pop that head.
  - Both FIFOs non-empty: pop the one the grant pointer names.
  - After any pop, the grant pointer flips to the other requester (round-robin).
- Issue:
  - On a pop, write_en <= (head.addr != 0), addressC <= head.addr, writeBack <= head.data.
  - Writes to x0 are consumed silently: popped, write_en stays 0, still counts as a grant.
  - With no pop, addressC and writeBack hold their values.
- Latency:
  - Handshake at posedge N puts the entry in the FIFO.
  - The earliest pop is in cycle N+1.
  - write_en is high during cycle N+2, and register_file samples it at the posedge ending N+2.
  - Steady-state throughput is one write per cycle total.
- Ordering across requesters:
  - No ordering guarantee; writes leave in grant order.
  - Same-register writes from both sources are the issuing stage's responsibility (use pending_mask).
- pending_mask (combinational from registered state):
  - Bit r set if any valid FIFO entry has addr r, or if (write_en && addressC == r).
  - Bit 0 is always 0.
- idle = both counts 0 && !write_en.

Optional Feature:
- WBARB_RR_EN.
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, load always wins when both are non-empty; the grant pointer is removed. Load-first keeps the memory pipeline from backing up.
- All other behaviour is identical in both builds.

Test Plan:
- Reset mid-traffic: both FIFOs full, assert reset one cycle -> next cycle write_en=0, addressC=0, writeBack=0, pending_mask=0, idle=1; alu_ready=ld_ready=1 after reset deasserts.
- Single ALU write: alu addr=5, data=0xDEAD at posedge N -> write_en=1, addressC=5, writeBack=0xDEAD during cycle N+2 only; pending_mask[5]=1 cycles N+1..N+2, then 0.
- Contention, WBARB_RR_EN defined: both sides push 2 entries at once (ALU r1,r2; LD r3,r4) -> addressC sequence 1,3,2,4 on consecutive cycles. Undefined: sequence 3,4,1,2.
- x0 suppression: ALU pushes addr=0, data=0xFFFF then addr=7 -> write_en low for the x0 slot, then high with addressC=7; pending_mask[0] never set.
- Backpressure: hold alu_valid=1 for 5 cycles with DEPTH=2 and the load side also streaming -> alu_ready drops when count=2; no entry lost or duplicated; ALU data order preserved.
- Simultaneous push/pop at full: FIFO at DEPTH, head popped in the same cycle a new push is offered -> push refused (ready=0); accepted the next cycle; count correct.
